gbuf_pingpong_sched: RTL and testbench

//  Schedules the ping-pong halves of Global Buffer-B between the MAC write path and the next-layer reader.
//  - Counts MAC i_cal_fin pulses to detect when one buffer half (one tile) is complete.
//  - Selects the half the write DMA targets; this is the write address MSB.
//  - Gates the MAC while the target half is still owned by the reader.
//  - Hands filled halves to the reader through a valid/done handshake.
//  - Signals completion of a layer of i_tile_num tiles.

---
 rtl/gbuf_pingpong_sched.sv | 129 ++++++++++++
 tb/tb_gbuf_pingpong_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuf_pingpong_sched.sv
// Ping-pong scheduler for the two halves of Global Buffer-B (MAC writer vs next-layer reader).
// Define GBUF_PERF_CNT_EN to add o_stall_cycles, a saturating count of cycles spent in WAIT_FREE.
module gbuf_pingpong_sched #(
  parameter int FIN_PER_WORD = 4,
  parameter int COLS         = 32,
  parameter int BANKS        = 16,
  parameter int TILE_W       = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [TILE_W-1:0] i_tile_num,
  input  logic              i_cal_fin,
  input  logic              i_rd_done,
  output logic              o_mac_en,
  output logic              o_wr_buf,
  output logic              o_wr_tile_done,
  output logic              o_rd_valid,
  output logic              o_rd_buf,
  output logic              o_busy,
  output logic              o_layer_done,
  output logic              o_err
`ifdef GBUF_PERF_CNT_EN
  ,
  output logic [31:0]       o_stall_cycles
`endif
);
  localparam int TILE_FIN = FIN_PER_WORD * COLS * BANKS;
  localparam int FIN_W = (TILE_FIN > 1) ? $clog2(TILE_FIN) : 1;
  localparam logic [FIN_W-1:0] FIN_LAST = FIN_W'(TILE_FIN - 1);

  typedef enum logic [2:0] {IDLE, FILL, WAIT_FREE, DRAIN, DONE} state_t;

  state_t            state, state_next;
  logic [TILE_W-1:0] tile_num_q, tile_cnt;
  logic [FIN_W-1:0]  fin_cnt;
  logic [1:0]        full, full_next;
  logic              wr_buf, rd_buf, mac_en, tile_done, err;
  logic              start_ok, fin_ok, last_fin, rd_valid, rd_release, last_tile, next_half_busy;

  always_comb begin
    start_ok   = i_start && (state == IDLE);
    fin_ok     = i_cal_fin && mac_en;
    last_fin   = fin_ok && (fin_cnt == FIN_LAST);
    rd_valid   = (state != IDLE) && full[rd_buf];
    rd_release = i_rd_done && rd_valid;
    last_tile  = (tile_cnt + TILE_W'(1)) == tile_num_q;
    // The half we toggle onto is blocked unless the reader frees it this very cycle
    next_half_busy = full[~wr_buf] && !(rd_release && (rd_buf != wr_buf));
    full_next = full;
    if (rd_release) full_next[rd_buf] = 1'b0;
    if (last_fin)   full_next[wr_buf] = 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (i_start) state_next = (i_tile_num == '0) ? DONE : FILL;
      FILL: begin
        if (last_fin) begin
          if (last_tile)           state_next = DRAIN;
          else if (next_half_busy) state_next = WAIT_FREE;
        end
      end
      WAIT_FREE: if (!full[wr_buf]) state_next = FILL;
      DRAIN:     if (full == 2'b00) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      tile_num_q <= '0;
      tile_cnt   <= '0;
      fin_cnt    <= '0;
      full       <= 2'b00;
      wr_buf     <= 1'b0;
      rd_buf     <= 1'b0;
      mac_en     <= 1'b0;
      tile_done  <= 1'b0;
      err        <= 1'b0;
    end else begin
      state     <= state_next;
      mac_en    <= (state_next == FILL);
      tile_done <= last_fin;
      if (start_ok) begin
        tile_num_q <= i_tile_num;
        tile_cnt   <= '0;
        fin_cnt    <= '0;
        full       <= 2'b00;
        wr_buf     <= 1'b0;
        rd_buf     <= 1'b0;
        err        <= 1'b0;
      end else begin
        full <= full_next;
        if (i_cal_fin && !mac_en) err <= 1'b1;
        if (fin_ok) fin_cnt <= last_fin ? '0 : fin_cnt + FIN_W'(1);
        if (last_fin) begin
          wr_buf   <= ~wr_buf;
          tile_cnt <= tile_cnt + TILE_W'(1);
        end
        if (rd_release) rd_buf <= ~rd_buf;
      end
    end
  end

`ifdef GBUF_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                              stall_cnt <= '0;
    else if (start_ok)                                      stall_cnt <= '0;
    else if (state == WAIT_FREE && stall_cnt != '1)         stall_cnt <= stall_cnt + 32'd1;
  end

  assign o_stall_cycles = stall_cnt;
`endif

  assign o_mac_en       = mac_en;
  assign o_wr_buf       = wr_buf;
  assign o_wr_tile_done = tile_done;
  assign o_rd_valid     = rd_valid;
  assign o_rd_buf       = rd_buf;
  assign o_busy         = (state != IDLE);
  assign o_layer_done   = (state == DONE);
  assign o_err          = err;
endmodule

// File: tb/tb_gbuf_pingpong_sched.sv
// Testbench for gbuf_pingpong_sched: rule-based buffer-ownership model checked every cycle,
// directed scenarios with literal expectations, then randomized layers.
module tb_gbuf_pingpong_sched;
  localparam int TILE_FIN = 4 * 32 * 16;
  localparam int TILE_W   = 16;

  logic              clk = 1'b0, rst = 1'b0;
  logic              start = 1'b0, cal_fin = 1'b0, rd_done = 1'b0;
  logic [TILE_W-1:0] tile_num = '0;
  logic mac_en, wr_buf, wr_tile_done, rd_valid, rd_buf, busy, layer_done, err;
`ifdef GBUF_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int tests = 0, fails = 0;
  int tileDoneSeen = 0, layerDoneSeen = 0;

  gbuf_pingpong_sched dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_tile_num(tile_num),
    .i_cal_fin(cal_fin),
    .o_mac_en(mac_en),
    .o_wr_buf(wr_buf),
    .o_wr_tile_done(wr_tile_done),
    .o_rd_valid(rd_valid),
    .o_rd_buf(rd_buf),
    .i_rd_done(rd_done),
    .o_busy(busy),
    .o_layer_done(layer_done),
    .o_err(err)
`ifdef GBUF_PERF_CNT_EN
    , .o_stall_cycles(stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: tracks which halves hold unread data and how many fins/tiles have landed
  bit          m_active = 0, m_mac_en = 0, m_wr = 0, m_rd = 0, m_err = 0;
  bit          m_tile_done = 0, m_layer_done = 0;
  bit [1:0]    m_full = 0;
  int          m_tile_num = 0, m_tiles = 0, m_fins = 0;
  longint      m_stall = 0;

  always @(posedge clk or posedge rst) begin : model
    bit       done_now, completes, released;
    bit [1:0] nf;
    if (rst) begin
      m_active = 0; m_mac_en = 0; m_wr = 0; m_rd = 0; m_err = 0;
      m_tile_done = 0; m_layer_done = 0; m_full = 0;
      m_tile_num = 0; m_tiles = 0; m_fins = 0; m_stall = 0;
    end else begin
      done_now = m_layer_done;
      m_tile_done = 0;
      m_layer_done = 0;
      if (!m_active) begin
        if (start) begin
          m_active = 1; m_tile_num = int'(tile_num); m_tiles = 0; m_fins = 0;
          m_full = 0; m_wr = 0; m_rd = 0; m_err = 0; m_stall = 0;
          m_mac_en = (tile_num != 0);
          m_layer_done = (tile_num == 0);
        end else if (cal_fin) m_err = 1;
      end else if (done_now) begin
        if (cal_fin) m_err = 1;
        m_active = 0;
        m_mac_en = 0;
      end else begin
        released = rd_done && m_full[m_rd];
        completes = 0;
        if (cal_fin) begin
          if (m_mac_en) begin
            m_fins++;
            if (m_fins == TILE_FIN) begin m_fins = 0; completes = 1; end
          end else m_err = 1;
        end
        if (!m_mac_en && m_tiles != m_tile_num && m_stall != 64'hFFFF_FFFF) m_stall++;
        nf = m_full;
        if (released) begin nf[m_rd] = 0; m_rd = !m_rd; end
        if (m_tiles == m_tile_num) begin
          if (m_full == 2'b00) m_layer_done = 1;
          m_mac_en = 0;
        end else begin
          if (completes) begin nf[m_wr] = 1; m_wr = !m_wr; m_tiles++; m_tile_done = 1; end
          if (m_tiles == m_tile_num) m_mac_en = 0;
          else if (m_mac_en)         m_mac_en = !nf[m_wr];
          else                       m_mac_en = !m_full[m_wr];
        end
        m_full = nf;
      end
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareAll();
    checkOutput("busy", longint'(busy), longint'(m_active));
    checkOutput("mac_en", longint'(mac_en), longint'(m_mac_en));
    checkOutput("wr_buf", longint'(wr_buf), longint'(m_wr));
    checkOutput("wr_tile_done", longint'(wr_tile_done), longint'(m_tile_done));
    checkOutput("rd_valid", longint'(rd_valid), longint'(m_active && m_full[m_rd]));
    checkOutput("rd_buf", longint'(rd_buf), longint'(m_rd));
    checkOutput("layer_done", longint'(layer_done), longint'(m_layer_done));
    checkOutput("err", longint'(err), longint'(m_err));
`ifdef GBUF_PERF_CNT_EN
    checkOutput("stall_cycles", longint'(stall_cycles), m_stall);
`endif
    if (wr_tile_done) tileDoneSeen++;
    if (layer_done)   layerDoneSeen++;
  endtask

  // Drive one cycle of inputs, then compare at the following falling edge
  task automatic applyStimulus(input logic s, input logic [TILE_W-1:0] tn, input logic f, input logic r);
    start = s; tile_num = tn; cal_fin = f; rd_done = r;
    @(negedge clk);
    compareAll();
  endtask

  task automatic feedFins(input int n);
    repeat (n) applyStimulus(1'b0, tile_num, 1'b1, 1'b0);
  endtask

  task automatic waitLayerDone(input int budget, input bit autoRead);
    int n;
    n = 0;
    while (!layer_done && n < budget) begin
      applyStimulus(1'b0, tile_num, 1'b0, autoRead && rd_valid);
      n++;
    end
    checkOutput("layer_done_wait", longint'(layer_done), 1);
    applyStimulus(1'b0, tile_num, 1'b0, 1'b0);
  endtask

  initial begin
    int td0, ld0;
    #1 rst = 1'b1;
    @(negedge clk); compareAll();
    @(negedge clk); compareAll();
    checkOutput("reset_outputs",
                longint'({mac_en, wr_buf, wr_tile_done, rd_valid, rd_buf, busy, layer_done, err}), 0);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);

    // T1: single tile, reader releases right after it lands
    td0 = tileDoneSeen; ld0 = layerDoneSeen;
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
    checkOutput("t1_mac_en_on", longint'(mac_en), 1);
    feedFins(TILE_FIN);
    checkOutput("t1_tile_done", longint'(wr_tile_done), 1);
    checkOutput("t1_wr_buf", longint'(wr_buf), 1);
    checkOutput("t1_rd_valid", longint'(rd_valid), 1);
    checkOutput("t1_rd_buf", longint'(rd_buf), 0);
    checkOutput("t1_mac_en_off", longint'(mac_en), 0);
    applyStimulus(1'b0, 16'd1, 1'b0, 1'b1);
    waitLayerDone(10, 1'b0);
    checkOutput("t1_busy_low", longint'(busy), 0);
    checkOutput("t1_tile_done_count", longint'(tileDoneSeen - td0), 1);
    checkOutput("t1_layer_done_count", longint'(layerDoneSeen - ld0), 1);

    // T2 + T4: three tiles, reader stalls, stray fin while gated
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
    feedFins(2 * TILE_FIN);
    checkOutput("t2_mac_gated", longint'(mac_en), 0);
    checkOutput("t2_wr_buf", longint'(wr_buf), 0);
    checkOutput("t2_rd_valid", longint'(rd_valid), 1);
    applyStimulus(1'b0, 16'd3, 1'b1, 1'b0);
    checkOutput("t4_err_set", longint'(err), 1);
    repeat (3) applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
    checkOutput("t2_still_gated", longint'(mac_en), 0);
    applyStimulus(1'b0, 16'd3, 1'b0, 1'b1);
    checkOutput("t2_rd_buf_toggle", longint'(rd_buf), 1);
    applyStimulus(1'b0, 16'd3, 1'b0, 1'b0);
    checkOutput("t2_mac_resume", longint'(mac_en), 1);
    feedFins(TILE_FIN);
    checkOutput("t2_third_tile_done", longint'(wr_tile_done), 1);
    checkOutput("t2_third_wr_toggle", longint'(wr_buf), 1);
    applyStimulus(1'b0, 16'd3, 1'b0, 1'b1);
    checkOutput("t2_third_in_half0", longint'({rd_valid, rd_buf}), 2);
    applyStimulus(1'b0, 16'd3, 1'b0, 1'b1);
    waitLayerDone(10, 1'b0);
    checkOutput("t4_err_sticky", longint'(err), 1);

    // T3: zero-tile layer, also clears the sticky error
    applyStimulus(1'b1, 16'd0, 1'b0, 1'b0);
    checkOutput("t3_layer_done", longint'(layer_done), 1);
    checkOutput("t3_mac_en", longint'(mac_en), 0);
    checkOutput("t4_err_cleared", longint'(err), 0);
    applyStimulus(1'b0, 16'd0, 1'b0, 1'b0);
    checkOutput("t3_idle", longint'(busy), 0);

    // T5: last fin of tile 2 coincides with release of half 0
    applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
    feedFins(2 * TILE_FIN - 1);
    applyStimulus(1'b0, 16'd3, 1'b1, 1'b1);
    checkOutput("t5_no_wait", longint'(mac_en), 1);
    checkOutput("t5_half1_valid", longint'({rd_valid, rd_buf}), 3);
    applyStimulus(1'b0, 16'd3, 1'b0, 1'b1);
    checkOutput("t5_all_free", longint'(rd_valid), 0);
    feedFins(TILE_FIN);
    waitLayerDone(20, 1'b1);

    // T6: reset mid-tile, then a clean single-tile layer
    applyStimulus(1'b1, 16'd2, 1'b0, 1'b0);
    feedFins(1000);
    rst = 1'b1;
    applyStimulus(1'b0, 16'd2, 1'b0, 1'b0);
    checkOutput("t6_rst_outputs",
                longint'({mac_en, wr_buf, wr_tile_done, rd_valid, rd_buf, busy, layer_done, err}), 0);
    rst = 1'b0;
    applyStimulus(1'b1, 16'd1, 1'b0, 1'b0);
    checkOutput("t6_restart_half0", longint'({mac_en, wr_buf}), 2);
    feedFins(TILE_FIN - 1);
    checkOutput("t6_not_yet", longint'(wr_tile_done), 0);
    feedFins(1);
    checkOutput("t6_full_count", longint'(wr_tile_done), 1);
    waitLayerDone(20, 1'b1);

    // Randomized layers
    for (int l = 0; l < 4; l++) begin
      logic [TILE_W-1:0] tn;
      int n;
      bit f, r, s;
      tn = TILE_W'($urandom_range(1, 4));
      n = 0;
      applyStimulus(1'b1, tn, 1'b0, 1'b0);
      while (!layer_done && n < 20000) begin
        f = mac_en ? ($urandom_range(0, 99) < 92) : ($urandom_range(0, 99) < 1);
        r = rd_valid ? ($urandom_range(0, 99) < 30) : ($urandom_range(0, 99) < 5);
        s = ($urandom_range(0, 99) < 1);
        applyStimulus(s, tn, f, r);
        n++;
      end
      checkOutput("rand_layer_done", longint'(layer_done), 1);
      applyStimulus(1'b0, tn, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
